// File: rtl/machine_control.sv
// Machine-mode trap sequencer: turns exception/interrupt/MRET events into CSR strobes, PC select and flush.
// Optional WFI wait state is built only when MCTRL_WFI_EN is defined; otherwise WFI retires as a NOP.
//
// state       | meaning
// RESET_ST    | held after reset, fetch from boot address, pipeline flushed
// OPERATING   | normal execution, trap/return detection
// TRAP_TAKEN  | bubble after trap entry
// TRAP_RETURN | bubble after mret
// WAIT_ST     | stalled on wfi until an enabled interrupt is pending (MCTRL_WFI_EN)
module machine_control #(
  parameter int RESET_HOLD = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RETIRE_VALID,
  input  logic       ILLEGAL_INSTR,
  input  logic       MISALIGNED_INSTR,
  input  logic       MISALIGNED_LOAD,
  input  logic       MISALIGNED_STORE,
  input  logic       ECALL,
  input  logic       EBREAK,
  input  logic       MRET,
  input  logic       WFI,
  input  logic       MIE,
  input  logic       MEIE_IN,
  input  logic       MTIE_IN,
  input  logic       MSIE_IN,
  input  logic       MEIP_IN,
  input  logic       MTIP_IN,
  input  logic       MSIP_IN,
  output logic       I_OR_E,
  output logic       SET_CAUSE,
  output logic [3:0] CAUSE_OUT,
  output logic       SET_EPC,
  output logic       INSTRET_INC,
  output logic       MIE_CLEAR,
  output logic       MIE_SET,
  output logic [1:0] PC_SRC,
  output logic       FLUSH,
  output logic       STALL
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_EPC  = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_NEXT = 2'b11;

  typedef enum logic [2:0] {
    RESET_ST    = 3'd0,
    OPERATING   = 3'd1,
    TRAP_TAKEN  = 3'd2,
    TRAP_RETURN = 3'd3
`ifdef MCTRL_WFI_EN
    , WAIT_ST   = 3'd4
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic       src_ext, src_sw, src_tmr, wake;
  logic       exc_any, irq_any, wfi_retire;
  logic [3:0] exc_cause, irq_cause;

  assign src_ext    = MEIE_IN & MEIP_IN;
  assign src_sw     = MSIE_IN & MSIP_IN;
  assign src_tmr    = MTIE_IN & MTIP_IN;
  assign wake       = src_ext | src_sw | src_tmr;
  assign exc_any    = RETIRE_VALID & (ILLEGAL_INSTR | MISALIGNED_INSTR | MISALIGNED_LOAD |
                                      MISALIGNED_STORE | ECALL | EBREAK);
  assign irq_any    = RETIRE_VALID & MIE & wake;
  assign wfi_retire = RETIRE_VALID & WFI;

  always_comb begin
    exc_cause = 4'd11;
    if (MISALIGNED_INSTR)      exc_cause = 4'd0;
    else if (ILLEGAL_INSTR)    exc_cause = 4'd2;
    else if (EBREAK)           exc_cause = 4'd3;
    else if (MISALIGNED_LOAD)  exc_cause = 4'd4;
    else if (MISALIGNED_STORE) exc_cause = 4'd6;
  end

  always_comb begin
    irq_cause = 4'd7;
    if (src_ext)     irq_cause = 4'd11;
    else if (src_sw) irq_cause = 4'd3;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= RESET_ST;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      RESET_ST: begin
        if (hold_cnt_q == HOLD_LAST) state_d = OPERATING;
        else                         hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
      OPERATING: begin
        if (exc_any || irq_any) state_d = TRAP_TAKEN;
        else if (MRET)          state_d = TRAP_RETURN;
`ifdef MCTRL_WFI_EN
        else if (wfi_retire)    state_d = WAIT_ST;
`endif
      end
      TRAP_TAKEN, TRAP_RETURN: state_d = OPERATING;
`ifdef MCTRL_WFI_EN
      WAIT_ST: if (wake) state_d = OPERATING;
`endif
      default: state_d = RESET_ST;
    endcase
  end

  always_comb begin
    I_OR_E      = 1'b0;
    SET_CAUSE   = 1'b0;
    CAUSE_OUT   = 4'd0;
    SET_EPC     = 1'b0;
    INSTRET_INC = 1'b0;
    MIE_CLEAR   = 1'b0;
    MIE_SET     = 1'b0;
    PC_SRC      = PC_NEXT;
    FLUSH       = 1'b0;
    STALL       = 1'b0;
    case (state_q)
      RESET_ST: begin
        PC_SRC = PC_BOOT;
        FLUSH  = 1'b1;
      end
      OPERATING: begin
        if (exc_any || irq_any) begin
          // exceptions outrank interrupts; the trapping instruction does not retire
          I_OR_E    = ~exc_any;
          SET_CAUSE = 1'b1;
          CAUSE_OUT = exc_any ? exc_cause : irq_cause;
          SET_EPC   = 1'b1;
          MIE_CLEAR = 1'b1;
          PC_SRC    = PC_TRAP;
          FLUSH     = 1'b1;
        end else if (MRET) begin
          MIE_SET     = 1'b1;
          INSTRET_INC = 1'b1;
          PC_SRC      = PC_EPC;
          FLUSH       = 1'b1;
        end else begin
          // a wfi retires like any other instruction, whether or not it then waits
          INSTRET_INC = RETIRE_VALID | wfi_retire;
        end
      end
      TRAP_TAKEN, TRAP_RETURN: FLUSH = 1'b1;
`ifdef MCTRL_WFI_EN
      WAIT_ST: STALL = ~wake;
`endif
      default: begin
        PC_SRC = PC_BOOT;
        FLUSH  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_machine_control.sv
// Directed bench for machine_control: reset hold, trap entry/return, priorities, masking and WFI.
module tb_machine_control;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       RETIRE_VALID, ILLEGAL_INSTR, MISALIGNED_INSTR, MISALIGNED_LOAD;
  logic       MISALIGNED_STORE, ECALL, EBREAK, MRET, WFI, MIE;
  logic       MEIE_IN, MTIE_IN, MSIE_IN, MEIP_IN, MTIP_IN, MSIP_IN;
  logic       I_OR_E, SET_CAUSE, SET_EPC, INSTRET_INC, MIE_CLEAR, MIE_SET, FLUSH, STALL;
  logic [3:0] CAUSE_OUT;
  logic [1:0] PC_SRC;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  machine_control #(.RESET_HOLD(2)) dut (
    .CLK(CLK), .RESET(RESET), .RETIRE_VALID(RETIRE_VALID),
    .ILLEGAL_INSTR(ILLEGAL_INSTR), .MISALIGNED_INSTR(MISALIGNED_INSTR),
    .MISALIGNED_LOAD(MISALIGNED_LOAD), .MISALIGNED_STORE(MISALIGNED_STORE),
    .ECALL(ECALL), .EBREAK(EBREAK), .MRET(MRET), .WFI(WFI), .MIE(MIE),
    .MEIE_IN(MEIE_IN), .MTIE_IN(MTIE_IN), .MSIE_IN(MSIE_IN),
    .MEIP_IN(MEIP_IN), .MTIP_IN(MTIP_IN), .MSIP_IN(MSIP_IN),
    .I_OR_E(I_OR_E), .SET_CAUSE(SET_CAUSE), .CAUSE_OUT(CAUSE_OUT), .SET_EPC(SET_EPC),
    .INSTRET_INC(INSTRET_INC), .MIE_CLEAR(MIE_CLEAR), .MIE_SET(MIE_SET),
    .PC_SRC(PC_SRC), .FLUSH(FLUSH), .STALL(STALL)
  );

  // {I_OR_E, SET_CAUSE, CAUSE_OUT, SET_EPC, INSTRET_INC, MIE_CLEAR, MIE_SET, PC_SRC, FLUSH, STALL}
  logic [13:0] obs;
  assign obs = {I_OR_E, SET_CAUSE, CAUSE_OUT, SET_EPC, INSTRET_INC, MIE_CLEAR, MIE_SET,
                PC_SRC, FLUSH, STALL};

  localparam logic [13:0] RST   = 14'b0_0_0000_0_0_0_0_00_1_0;
  localparam logic [13:0] BUB   = 14'b0_0_0000_0_0_0_0_11_1_0;
  localparam logic [13:0] RUN0  = 14'b0_0_0000_0_0_0_0_11_0_0;
  localparam logic [13:0] RUN1  = 14'b0_0_0000_0_1_0_0_11_0_0;
  localparam logic [13:0] RET   = 14'b0_0_0000_0_1_0_1_01_1_0;
  localparam logic [13:0] WAITV = 14'b0_0_0000_0_0_0_0_11_0_1;

  function automatic logic [13:0] trap(input logic ioe, input logic [3:0] cause);
    return {ioe, 1'b1, cause, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [13:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clr();
    RETIRE_VALID = 0; ILLEGAL_INSTR = 0; MISALIGNED_INSTR = 0; MISALIGNED_LOAD = 0;
    MISALIGNED_STORE = 0; ECALL = 0; EBREAK = 0; MRET = 0; WFI = 0; MIE = 0;
    MEIE_IN = 0; MTIE_IN = 0; MSIE_IN = 0; MEIP_IN = 0; MTIP_IN = 0; MSIP_IN = 0;
  endtask

  task automatic nx();
    @(negedge CLK);
    clr();
  endtask

  task automatic exc_step(input string tag, input logic mi, il, eb, ml, ms, ec,
                          input logic [3:0] cause);
    nx(); RETIRE_VALID = 1;
    MISALIGNED_INSTR = mi; ILLEGAL_INSTR = il; EBREAK = eb;
    MISALIGNED_LOAD = ml; MISALIGNED_STORE = ms; ECALL = ec;
    #1 chk(tag, trap(1'b0, cause));
    nx(); #1 chk({tag, "_bubble"}, BUB);
  endtask

  initial begin
    clr();
    RESET = 1;
    repeat (3) begin @(negedge CLK); #1 chk("reset_hold", RST); end
    @(negedge CLK); RESET = 0; #1 chk("release_1", RST);
    @(negedge CLK); #1 chk("release_2", RST);
    @(negedge CLK); #1 chk("operating_idle", RUN0);
    nx(); RETIRE_VALID = 1; #1 chk("retire", RUN1);

    nx(); RETIRE_VALID = 1; ILLEGAL_INSTR = 1; #1 chk("illegal", trap(1'b0, 4'd2));
    @(negedge CLK); #1 chk("bubble_no_retrap", BUB);
    nx(); #1 chk("after_bubble", RUN0);

    nx(); RETIRE_VALID = 1; MIE = 1; MTIE_IN = 1; MTIP_IN = 1; MEIE_IN = 1; MEIP_IN = 1;
    #1 chk("irq_ext_over_timer", trap(1'b1, 4'd11));
    @(negedge CLK); #1 chk("irq_bubble", BUB);
    @(negedge CLK); MIE = 0; #1 chk("irq_masked_retires", RUN1);

    nx(); RETIRE_VALID = 1; MIE = 1; MTIE_IN = 1; MTIP_IN = 1;
    #1 chk("irq_timer", trap(1'b1, 4'd7));
    nx(); #1 chk("irq_timer_bubble", BUB);
    nx(); RETIRE_VALID = 1; MIE = 1; MTIE_IN = 1; MTIP_IN = 1; MSIE_IN = 1; MSIP_IN = 1;
    #1 chk("irq_sw_over_timer", trap(1'b1, 4'd3));
    nx(); #1 chk("irq_sw_bubble", BUB);
    nx(); RETIRE_VALID = 1; MIE = 1; MEIE_IN = 1; MSIP_IN = 1;
    #1 chk("irq_enable_pending_mismatch", RUN1);

    nx(); RETIRE_VALID = 1; ECALL = 1; MIE = 1; MEIE_IN = 1; MEIP_IN = 1; MRET = 1;
    #1 chk("ecall_irq_mret", trap(1'b0, 4'd11));
    nx(); #1 chk("ecall_bubble", BUB);

    exc_step("misinstr_over_ecall", 1, 0, 0, 0, 0, 1, 4'd0);
    exc_step("illegal_over_ebreak", 0, 1, 1, 0, 0, 0, 4'd2);
    exc_step("ebreak_over_load",    0, 0, 1, 1, 0, 0, 4'd3);
    exc_step("load_over_store",     0, 0, 0, 1, 1, 0, 4'd4);
    exc_step("store",               0, 0, 0, 0, 1, 0, 4'd6);

    nx(); RETIRE_VALID = 1; MIE = 1; MSIE_IN = 1; MSIP_IN = 1; MRET = 1;
    #1 chk("irq_over_mret", trap(1'b1, 4'd3));
    nx(); #1 chk("irq_mret_bubble", BUB);
    nx(); ILLEGAL_INSTR = 1; #1 chk("exc_without_retire", RUN0);

`ifdef MCTRL_WFI_EN
    nx(); RETIRE_VALID = 1; WFI = 1; #1 chk("wfi_retire", RUN1);
    repeat (5) begin nx(); #1 chk("wfi_stall", WAITV); end
    nx(); MSIE_IN = 1; MSIP_IN = 1; #1 chk("wfi_wake", RUN0);
    @(negedge CLK); #1 chk("wfi_no_trap_mie0", RUN0);
`else
    nx(); RETIRE_VALID = 1; WFI = 1; #1 chk("wfi_nop", RUN1);
    repeat (2) begin nx(); #1 chk("wfi_no_stall", RUN0); end
`endif

    nx(); RETIRE_VALID = 1; MRET = 1; #1 chk("mret", RET);
    nx(); RESET = 1; #1 chk("mret_bubble_in_reset", BUB);
    @(negedge CLK); #1 chk("reset_mid_run", RST);
    @(negedge CLK); RESET = 0; #1 chk("rerelease_1", RST);
    @(negedge CLK); #1 chk("rerelease_2", RST);
    @(negedge CLK); #1 chk("rerelease_run", RUN0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
